clk_div_prog: RTL and testbench

//   Runtime-programmable integer clock-divider stage. The divisor is loaded over a valid/ready handshake.
//   A mod-D counter produces a registered divided output (50% duty for even D; high for ceil(D/2) cycles for odd D).
//   It also produces single-cycle rise/fall strobes for downstream single-clock logic.
//   A new divisor takes effect only at a period boundary, so no truncated or glitched period ever appears on clk_out.

---
 rtl/clk_div_prog_pkg.sv | 13 +
 rtl/clk_div_prog_if.sv | 30 +++
 rtl/clk_div_prog_div_cfg_slot.sv | 45 ++++
 rtl/clk_div_prog.sv | 77 +++++++
 tb/tb_clk_div_prog.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_prog_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int DEFAULT_W   = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int MIN_DIV     = 2;

    // High-phase length. For odd divisors this rounds up.
    function automatic int unsigned half_len(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Divisor-load handshake bus between a configuration master and the divider.
interface clk_div_prog_if
    import clk_div_pkg::*;
#(
    parameter int W = DEFAULT_W
);

    logic [W-1:0] div_in;
    logic         div_valid;
    logic         div_ready;
    logic         div_err;
    logic         div_apply;

    modport master (
        output div_in,
        output div_valid,
        input  div_ready,
        input  div_err,
        input  div_apply
    );

    modport slave (
        input  div_in,
        input  div_valid,
        output div_ready,
        output div_err,
        output div_apply
    );

endinterface

// File: rtl/clk_div_prog_div_cfg_slot.sv
// Single-entry divisor holding slot: accepts a divisor over valid/ready and
// keeps it pending until the counter applies it at a period boundary.
module div_cfg_slot
    import clk_div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         apply,
    output logic         ready,
    output logic         err,
    output logic         pend_vld,
    output logic [W-1:0] pend_div
);

    logic xfer;
    logic legal;

    assign ready = ~pend_vld;
    assign xfer  = valid && ready;
    assign legal = (data >= W'(MIN_DIV));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_vld <= 1'b0;
            pend_div <= '0;
            err      <= 1'b0;
        end else begin
            err <= xfer && !legal;
            // apply and xfer are mutually exclusive: apply needs pend_vld, xfer needs ready
            if (apply) begin
                pend_vld <= 1'b0;
            end else if (xfer && legal) begin
                pend_vld <= 1'b1;
                pend_div <= data;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with registered output, edge
// strobes, and glitch-free divisor switching at period boundaries.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    clk_div_prog_if.slave cfg,
    output logic         clk_out,
    output logic         tick_rise,
    output logic         tick_fall,
    output logic [W-1:0] cnt
);

    logic [W-1:0] div_cur;
    logic [W-1:0] cnt_next;
    logic [W-1:0] d_eff;
    logic [W:0]   h_eff;
    logic [W-1:0] pend_div;
    logic         pend_vld;
    logic         wrap;
    logic         apply;
    logic         apply_q;
    logic         clk_next;

    div_cfg_slot #(.W(W)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .valid    (cfg.div_valid),
        .data     (cfg.div_in),
        .apply    (apply),
        .ready    (cfg.div_ready),
        .err      (cfg.div_err),
        .pend_vld (pend_vld),
        .pend_div (pend_div)
    );

    assign wrap     = (cnt == div_cur - W'(1));
    assign cnt_next = wrap ? '0 : cnt + W'(1);
    assign apply    = en && wrap && pend_vld;
    // On an apply edge the new period starts immediately, so use the new divisor's half length.
    assign d_eff    = apply ? pend_div : div_cur;
    assign h_eff    = (W+1)'(half_len(32'(d_eff)));
    assign clk_next = ({1'b0, cnt_next} < h_eff);

    assign cfg.div_apply = apply_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            div_cur   <= W'(DEF_DIV);
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            apply_q   <= 1'b0;
        end else begin
            apply_q <= apply;
            if (en) begin
                cnt       <= cnt_next;
                clk_out   <= clk_next;
                tick_rise <= clk_next & ~clk_out;
                tick_fall <= ~clk_next & clk_out;
                if (apply) begin
                    div_cur <= pend_div;
                end
            end else begin
                tick_rise <= 1'b0;
                tick_fall <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; expected values are hand-derived edge by edge.
module tb_clk_div_prog;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic         clk_out;
    logic         tick_rise;
    logic         tick_fall;
    logic [W-1:0] cnt;

    int n_tests;
    int n_fail;

    clk_div_prog_if #(.W(W)) cfg_bus ();

    clk_div_prog #(.W(W), .DEF_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cfg_bus),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int c, input logic co,
                              input logic r, input logic f);
        check({tag, ".cnt"}, 32'(cnt), 32'(c));
        check({tag, ".clk_out"}, 32'(clk_out), 32'(co));
        check({tag, ".rise"}, 32'(tick_rise), 32'(r));
        check({tag, ".fall"}, 32'(tick_fall), 32'(f));
    endtask

    task automatic load(input logic [W-1:0] d);
        cfg_bus.div_in    = d;
        cfg_bus.div_valid = 1'b1;
    endtask

    initial begin
        int highs;
        int rises;
        int falls;
        int max_cnt;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        en  = 1'b1;
        cfg_bus.div_in    = '0;
        cfg_bus.div_valid = 1'b0;

        // Reset state
        step();
        expect_out("rst", 0, 1'b0, 1'b0, 1'b0);
        check("rst.ready", 32'(cfg_bus.div_ready), 1);
        check("rst.err", 32'(cfg_bus.div_err), 0);
        check("rst.apply", 32'(cfg_bus.div_apply), 0);
        rst = 1'b1;

        // D=2 default: period 2
        step(); expect_out("d2.e1", 1, 1'b0, 1'b0, 1'b0);
        step(); expect_out("d2.e2", 0, 1'b1, 1'b1, 1'b0);
        step(); expect_out("d2.e3", 1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("d2.e4", 0, 1'b1, 1'b1, 1'b0);
        check("d2.ready", 32'(cfg_bus.div_ready), 1);

        // Load 4 mid-period; D=2 period completes first
        load(8'd4);
        step(); expect_out("l4.e5", 1, 1'b0, 1'b0, 1'b1);
        check("l4.ready_low", 32'(cfg_bus.div_ready), 0);
        check("l4.no_apply", 32'(cfg_bus.div_apply), 0);
        cfg_bus.div_valid = 1'b0;
        step(); expect_out("l4.e6", 0, 1'b1, 1'b1, 1'b0);
        check("l4.apply", 32'(cfg_bus.div_apply), 1);
        check("l4.ready_back", 32'(cfg_bus.div_ready), 1);
        step(); expect_out("d4.e7", 1, 1'b1, 1'b0, 1'b0);
        check("d4.apply_clr", 32'(cfg_bus.div_apply), 0);
        step(); expect_out("d4.e8", 2, 1'b0, 1'b0, 1'b1);
        step(); expect_out("d4.e9", 3, 1'b0, 1'b0, 1'b0);
        step(); expect_out("d4.e10", 0, 1'b1, 1'b1, 1'b0);

        // Load 5: 3 high / 2 low
        load(8'd5);
        step(); expect_out("l5.e11", 1, 1'b1, 1'b0, 1'b0);
        cfg_bus.div_valid = 1'b0;
        step(); expect_out("l5.e12", 2, 1'b0, 1'b0, 1'b1);
        step(); expect_out("l5.e13", 3, 1'b0, 1'b0, 1'b0);
        step(); expect_out("l5.e14", 0, 1'b1, 1'b1, 1'b0);
        check("l5.apply", 32'(cfg_bus.div_apply), 1);
        highs = 0; rises = 0; falls = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("d5.cnt", 32'(cnt), 32'(i % 5));
            highs += int'(clk_out);
            rises += int'(tick_rise);
            falls += int'(tick_fall);
        end
        check("d5.highs", 32'(highs), 3);
        check("d5.rises", 32'(rises), 1);
        check("d5.falls", 32'(falls), 1);

        // Illegal divisors 1 and 0
        load(8'd1);
        step();
        check("e1.err", 32'(cfg_bus.div_err), 1);
        check("e1.ready", 32'(cfg_bus.div_ready), 1);
        check("e1.cnt", 32'(cnt), 1);
        load(8'd0);
        step();
        check("e0.err", 32'(cfg_bus.div_err), 1);
        check("e0.ready", 32'(cfg_bus.div_ready), 1);
        cfg_bus.div_valid = 1'b0;
        step();
        check("e.err_clr", 32'(cfg_bus.div_err), 0);
        check("e.cnt3", 32'(cnt), 3);
        step(); check("e.cnt4", 32'(cnt), 4);
        step(); expect_out("e.wrap", 0, 1'b1, 1'b1, 1'b0);
        check("e.no_apply", 32'(cfg_bus.div_apply), 0);

        // en=0 for 7 cycles with a pending 3
        load(8'd3);
        step(); expect_out("en.e25", 1, 1'b1, 1'b0, 1'b0);
        cfg_bus.div_valid = 1'b0;
        step(); expect_out("en.e26", 2, 1'b1, 1'b0, 1'b0);
        step(); expect_out("en.e27", 3, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            expect_out("en.hold", 3, 1'b0, 1'b0, 1'b0);
            check("en.hold_ready", 32'(cfg_bus.div_ready), 0);
        end
        en = 1'b1;
        step(); expect_out("en.e35", 4, 1'b0, 1'b0, 1'b0);
        check("en.no_apply", 32'(cfg_bus.div_apply), 0);
        step(); expect_out("en.e36", 0, 1'b1, 1'b1, 1'b0);
        check("en.apply", 32'(cfg_bus.div_apply), 1);
        step(); expect_out("d3.e37", 1, 1'b1, 1'b0, 1'b0);
        step(); expect_out("d3.e38", 2, 1'b0, 1'b0, 1'b1);
        step(); expect_out("d3.e39", 0, 1'b1, 1'b1, 1'b0);

        // D=9 with a pending 6, then reset mid-period
        load(8'd9);
        step(); expect_out("r.e40", 1, 1'b1, 1'b0, 1'b0);
        cfg_bus.div_valid = 1'b0;
        step(); expect_out("r.e41", 2, 1'b0, 1'b0, 1'b1);
        step(); expect_out("r.e42", 0, 1'b1, 1'b1, 1'b0);
        check("r.apply9", 32'(cfg_bus.div_apply), 1);
        load(8'd6);
        step(); check("r.cnt1", 32'(cnt), 1);
        check("r.ready_low", 32'(cfg_bus.div_ready), 0);
        cfg_bus.div_valid = 1'b0;
        step(); check("r.cnt2", 32'(cnt), 2);
        step(); check("r.cnt3", 32'(cnt), 3);
        rst = 1'b0;
        step();
        expect_out("r.reset", 0, 1'b0, 1'b0, 1'b0);
        check("r.reset_ready", 32'(cfg_bus.div_ready), 1);
        rst = 1'b1;
        step(); expect_out("r.e47", 1, 1'b0, 1'b0, 1'b0);
        step(); expect_out("r.e48", 0, 1'b1, 1'b1, 1'b0);
        check("r.no_apply6", 32'(cfg_bus.div_apply), 0);
        step(); expect_out("r.e49", 1, 1'b0, 1'b0, 1'b1);

        // Accept coincides with a wrap: stored only, applied one period later; D=255 boundary
        load(8'd255);
        step(); expect_out("m.e50", 0, 1'b1, 1'b1, 1'b0);
        check("m.no_apply", 32'(cfg_bus.div_apply), 0);
        check("m.ready_low", 32'(cfg_bus.div_ready), 0);
        cfg_bus.div_valid = 1'b0;
        step(); expect_out("m.e51", 1, 1'b0, 1'b0, 1'b1);
        step(); expect_out("m.e52", 0, 1'b1, 1'b1, 1'b0);
        check("m.apply", 32'(cfg_bus.div_apply), 1);
        highs = 0; rises = 0; falls = 0; max_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            highs += int'(clk_out);
            rises += int'(tick_rise);
            falls += int'(tick_fall);
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        end
        check("d255.highs", 32'(highs), 128);
        check("d255.rises", 32'(rises), 1);
        check("d255.falls", 32'(falls), 1);
        check("d255.max_cnt", 32'(max_cnt), 254);
        check("d255.end_cnt", 32'(cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
